// File: rtl/sm_fetch_buffer.sv
// sm_fetch_buffer: instruction prefetch stage sitting between the node ROM and decode.
// Fetches one word per cycle into a small {pc, instr} FIFO and hands entries to
// decode over valid/ready. A redirect flushes the queue and restarts at a new PC.
module sm_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter int          ROM_SIZE = 128,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_a,
    input  logic [31:0] rom_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [29:0]   ROM_WORDS = 30'(ROM_SIZE);
    localparam logic [31:0]   PC_RESET  = {RESET_PC[31:2], 2'b00};

    logic [31:0]   fetchPc_q, fetchPc_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [CW-1:0] count_q, count_d;

    // Entry storage is deliberately left unreset; out_valid masks stale contents.
    logic [31:0] pcMem_q    [DEPTH];
    logic [31:0] instrMem_q [DEPTH];

    logic inRange;
    logic push;
    logic pop;

    assign inRange    = (fetchPc_q[31:2] < ROM_WORDS);
    assign fetch_done = !inRange;
    assign rom_a      = {2'b00, fetchPc_q[31:2]};

    assign out_valid  = (count_q != '0);
    assign out_instr  = instrMem_q[rdPtr_q];
    assign out_pc     = pcMem_q[rdPtr_q];

    // A full queue can still take a new word when decode drains the head this cycle.
    assign pop  = out_valid && out_ready;
    assign push = inRange && ((count_q < CNT_DEPTH) || pop) && !redirect_valid;

    // Next-state for the fetch PC, pointers and occupancy; redirect flushes everything.
    always_comb begin
        fetchPc_d = fetchPc_q;
        rdPtr_d   = rdPtr_q;
        wrPtr_d   = wrPtr_q;
        count_d   = count_q;
        if (redirect_valid) begin
            fetchPc_d = {redirect_pc[31:2], 2'b00};
            rdPtr_d   = '0;
            wrPtr_d   = '0;
            count_d   = '0;
        end else begin
            if (push) begin
                wrPtr_d   = wrPtr_q + PTR_ONE;
                fetchPc_d = fetchPc_q + 32'd4;
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // Control registers with synchronous reset back to the boot PC and an empty queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc_q <= PC_RESET;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
        end else begin
            fetchPc_q <= fetchPc_d;
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
            count_q   <= count_d;
        end
    end

    // Capture the fetched word alongside its byte PC at the write pointer.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pcMem_q[wrPtr_q]    <= fetchPc_q;
            instrMem_q[wrPtr_q] <= rom_rd;
        end
    end

endmodule

// File: tb/tb_sm_fetch_buffer.sv
// Testbench for sm_fetch_buffer: directed scenarios followed by random traffic,
// all checked against a queue-based model of the fetch buffer behaviour.
module tb_sm_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam int          ROM_SIZE = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_a;
    logic [31:0] rom_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_done;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] mPc;
    int          compared   = 0;
    int          mismatched = 0;

    sm_fetch_buffer #(
        .DEPTH   (DEPTH),
        .ROM_SIZE(ROM_SIZE),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_a         (rom_a),
        .rom_rd        (rom_rd),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .fetch_done    (fetch_done)
    );

    always #5 clk = ~clk;

    // ROM contents: word k holds 0x1000_0000 + k.
    assign rom_rd = 32'h1000_0000 + rom_a;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        bit          valid;
        bit          popNow;
        bit          pushNow;
        bit          inRange;
        logic [31:0] wordAddr;
        if (rst) begin
            mq.delete();
            mPc = RESET_PC & ~32'h3;
            return;
        end
        wordAddr = mPc >> 2;
        valid    = (mq.size() != 0);
        popNow   = valid && out_ready;
        inRange  = (wordAddr < ROM_SIZE);
        pushNow  = inRange && ((mq.size() < DEPTH) || popNow) && !redirect_valid;
        if (redirect_valid) begin
            mq.delete();
            mPc = redirect_pc & ~32'h3;
        end else begin
            if (popNow) mq.delete(0);
            if (pushNow) begin
                mq.push_back('{pc: mPc, instr: 32'h1000_0000 + wordAddr});
                mPc = mPc + 32'd4;
            end
        end
    endtask

    task automatic checkState();
        checkOutput("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        checkOutput("fetch_done", 32'(fetch_done), 32'((mPc >> 2) >= ROM_SIZE));
        checkOutput("rom_a", rom_a, mPc >> 2);
        if (mq.size() != 0) begin
            checkOutput("out_pc", out_pc, mq[0].pc);
            checkOutput("out_instr", out_instr, mq[0].instr);
        end
    endtask

    // Check outputs mid-cycle, then drive the next cycle's inputs and step the model.
    task automatic applyStimulus(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
        @(negedge clk);
        checkState();
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        modelStep();
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        mq.delete();
        mPc = RESET_PC & ~32'h3;

        $display("[TB] streaming");
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] backpressure");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] redirect");
        applyStimulus(1'b0, 1'b1, 32'h43, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] rom end");
        applyStimulus(1'b0, 1'b1, 32'((ROM_SIZE - 3) * 4), 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);

        $display("[TB] full queue with simultaneous push and pop");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] mid-stream reset");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h20, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 15) == 0,
                          32'($urandom_range(0, ROM_SIZE * 4 + 16)),
                          $urandom_range(0, 3) != 0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkState();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
